trng_sample_ctrl: RTL and testbench

//  Sequencer for the ring-oscillator TRNG core: powers the oscillators, waits out warm-up,

---
 rtl/trng_pkg.sv | 18 +
 rtl/trng_health_test.sv | 71 +++++++
 rtl/trng_sample_ctrl.sv | 151 +++++++++++++++
 tb/tb_trng_sample_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and default thresholds for the ring-oscillator TRNG sample controller.
package trng_pkg;

    localparam int unsigned DEF_WARMUP_CYCLES = 256;
    localparam int unsigned DEF_SAMPLE_DIV    = 8;
    localparam int unsigned DEF_RCT_CUTOFF    = 32;
    localparam int unsigned DEF_APT_WINDOW    = 512;
    localparam int unsigned DEF_APT_CUTOFF    = 400;
    localparam int unsigned BYTE_W            = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WARMUP = 2'b01,
        ST_SAMPLE = 2'b10,
        ST_FAIL   = 2'b11
    } trng_state_e;

endpackage

// File: rtl/trng_health_test.sv
// Continuous SP800-90B health tests (repetition count + adaptive proportion) on decimated samples.
module trng_health_test
    import trng_pkg::*;
#(
    parameter int unsigned RCT_CUTOFF = DEF_RCT_CUTOFF,
    parameter int unsigned APT_WINDOW = DEF_APT_WINDOW,
    parameter int unsigned APT_CUTOFF = DEF_APT_CUTOFF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sample_vld,
    input  logic sample,
    output logic fail_c
);

    localparam int unsigned RCT_W  = $clog2(RCT_CUTOFF);
    localparam int unsigned APT_IW = $clog2(APT_WINDOW);
    localparam int unsigned APT_CW = $clog2(APT_CUTOFF);

    logic              rct_last;
    logic [RCT_W-1:0]  rct_run;
    logic              apt_ref;
    logic [APT_IW-1:0] apt_idx;
    logic [APT_CW-1:0] apt_cnt;

    logic [31:0] rct_nxt;
    logic [31:0] apt_cnt_nxt;
    logic [31:0] apt_idx_nxt;

    // Counts evaluated in 32 bits so the cutoff compare never sees a wrapped value.
    always_comb begin
        rct_nxt     = 32'd1;
        apt_cnt_nxt = 32'd1;
        apt_idx_nxt = 32'(apt_idx) + 32'd1;
        if (rct_run != '0 && sample == rct_last) begin
            rct_nxt = 32'(rct_run) + 32'd1;
        end
        if (apt_idx != '0) begin
            apt_cnt_nxt = (sample == apt_ref) ? 32'(apt_cnt) + 32'd1 : 32'(apt_cnt);
        end
    end

    assign fail_c = sample_vld && ((rct_nxt >= RCT_CUTOFF) || (apt_cnt_nxt >= APT_CUTOFF));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rct_last <= 1'b0;
            rct_run  <= '0;
            apt_ref  <= 1'b0;
            apt_idx  <= '0;
            apt_cnt  <= '0;
        end else if (clr) begin
            rct_last <= 1'b0;
            rct_run  <= '0;
            apt_ref  <= 1'b0;
            apt_idx  <= '0;
            apt_cnt  <= '0;
        end else if (sample_vld) begin
            rct_last <= sample;
            rct_run  <= RCT_W'(rct_nxt);
            apt_cnt  <= APT_CW'(apt_cnt_nxt);
            if (apt_idx == '0) begin
                apt_ref <= sample;
            end
            // Index wraps so the next sample opens a fresh window with a new reference.
            apt_idx <= (apt_idx_nxt == APT_WINDOW) ? '0 : APT_IW'(apt_idx_nxt);
        end
    end

endmodule

// File: rtl/trng_sample_ctrl.sv
// TRNG sequencer: oscillator power/warm-up, raw-bit decimation, health-test gating and byte packing.
module trng_sample_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int unsigned SAMPLE_DIV    = DEF_SAMPLE_DIV,
    parameter int unsigned RCT_CUTOFF    = DEF_RCT_CUTOFF,
    parameter int unsigned APT_WINDOW    = DEF_APT_WINDOW,
    parameter int unsigned APT_CUTOFF    = DEF_APT_CUTOFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              raw_bit,
    input  logic              clear_fail,
    input  logic              byte_ready,
    output logic              osc_en,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    output logic              fail,
    output logic [1:0]        state
);

    localparam int unsigned WARM_W = $clog2(WARMUP_CYCLES);
    localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned BIT_W  = $clog2(BYTE_W);

    trng_state_e       state_q;
    logic [WARM_W-1:0] warm_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BYTE_W-2:0] shreg;
    logic              raw_s1;
    logic              raw_sync;

    logic              sample_vld_c;
    logic              health_fail_c;
    logic [BYTE_W-1:0] byte_nxt_c;

    // Two-flop synchronizer for the free-running oscillator output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_s1   <= 1'b0;
            raw_sync <= 1'b0;
        end else begin
            raw_s1   <= raw_bit;
            raw_sync <= raw_s1;
        end
    end

    assign sample_vld_c = (state_q == ST_SAMPLE) && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign byte_nxt_c   = {shreg, raw_sync};
    assign state        = 2'(state_q);

    trng_health_test #(
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_health (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_q != ST_SAMPLE),
        .sample_vld (sample_vld_c),
        .sample     (raw_sync),
        .fail_c     (health_fail_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            osc_en     <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            fail       <= 1'b0;
            warm_cnt   <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q  <= ST_WARMUP;
                        osc_en   <= 1'b1;
                        warm_cnt <= '0;
                    end
                end
                ST_WARMUP: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        osc_en  <= 1'b0;
                    end else if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1)) begin
                        state_q <= ST_SAMPLE;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end else begin
                        warm_cnt <= warm_cnt + WARM_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    // Health failure wins; the byte completing on the failing sample is lost.
                    if (health_fail_c) begin
                        state_q    <= ST_FAIL;
                        fail       <= 1'b1;
                        osc_en     <= 1'b0;
                        byte_valid <= 1'b0;
                        bit_cnt    <= '0;
                    end else if (!enable) begin
                        state_q    <= ST_IDLE;
                        osc_en     <= 1'b0;
                        byte_valid <= 1'b0;
                        bit_cnt    <= '0;
                    end else begin
                        if (byte_valid && byte_ready) begin
                            byte_valid <= 1'b0;
                        end
                        if (sample_vld_c) begin
                            div_cnt <= '0;
                            shreg   <= byte_nxt_c[BYTE_W-2:0];
                            if (bit_cnt == BIT_W'(BYTE_W - 1)) begin
                                bit_cnt <= '0;
                                if (!byte_valid || byte_ready) begin
                                    byte_out   <= byte_nxt_c;
                                    byte_valid <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                end
                ST_FAIL: begin
                    if (clear_fail) begin
                        fail <= 1'b0;
                        if (enable) begin
                            state_q  <= ST_WARMUP;
                            osc_en   <= 1'b1;
                            warm_cnt <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Bench for trng_sample_ctrl: sample-history reference model checked every cycle plus directed scenarios.
module tb_trng_sample_ctrl;

    localparam int WARM = 256;
    localparam int DIV  = 8;
    localparam int RCT  = 32;
    localparam int WIN  = 512;
    localparam int APTC = 400;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       raw_bit;
    logic       clear_fail;
    logic       byte_ready;
    logic       osc_en;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       fail;
    logic [1:0] state;

    int n_tests;
    int n_fail;
    int pat_mode;

    trng_sample_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .raw_bit    (raw_bit),
        .clear_fail (clear_fail),
        .byte_ready (byte_ready),
        .osc_en     (osc_en),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .fail       (fail),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Raw bit chosen per sample index k (0 = first sample after warm-up).
    function automatic bit pattern(input int mode, input int k);
        case (mode)
            0:       return bit'(k % 2);
            1:       return 1'b1;
            2:       return (k % 5) != 4;
            default: return (k < 24) ? (k % 3 == 0) : bit'(k % 2);
        endcase
    endfunction

    // Reference model: states 0 IDLE, 1 WARMUP, 2 SAMPLE, 3 FAIL; every accepted sample kept in hist.
    int         m_st;
    int         m_cnt;
    bit         m_osc;
    bit         m_bv;
    bit         m_fail;
    logic [7:0] m_byte;
    bit         m_s1;
    bit         m_s2;
    bit         m_syn;
    bit         m_took;
    bit         m_canld;
    bit         m_smp;
    bit         m_bad;
    bit         m_done;
    logic [7:0] m_nb;
    bit         hist[$];

    function automatic int trailing_run();
        int r;
        r = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size() - 1]) break;
            r++;
        end
        return r;
    endfunction

    function automatic int window_matches();
        int last;
        int start;
        int c;
        last  = hist.size() - 1;
        start = (last / WIN) * WIN;
        c     = 0;
        for (int i = start; i <= last; i++) begin
            if (hist[i] == hist[start]) c++;
        end
        return c;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_cnt = 0; m_osc = 0; m_bv = 0; m_fail = 0; m_byte = 8'h00;
            m_s1 = 0; m_s2 = 0;
            hist.delete();
        end else begin
            m_syn = m_s2;
            m_s2  = m_s1;
            m_s1  = raw_bit;
            case (m_st)
                0: if (enable) begin m_st = 1; m_cnt = 0; m_osc = 1; hist.delete(); end
                1: begin
                    if (!enable) begin m_st = 0; m_osc = 0; end
                    else if (m_cnt == WARM - 1) begin m_st = 2; m_cnt = 0; hist.delete(); end
                    else m_cnt++;
                end
                2: begin
                    m_took  = m_bv && byte_ready;
                    m_canld = !m_bv || byte_ready;
                    m_smp   = ((m_cnt + 1) % DIV) == 0;
                    m_bad   = 0;
                    m_done  = 0;
                    m_nb    = 8'h00;
                    if (m_smp) begin
                        hist.push_back(m_syn);
                        m_bad  = (trailing_run() >= RCT) || (window_matches() >= APTC);
                        m_done = (hist.size() % 8) == 0;
                        if (m_done) begin
                            for (int i = hist.size() - 8; i < hist.size(); i++) m_nb = {m_nb[6:0], hist[i]};
                        end
                    end
                    if (m_bad) begin m_st = 3; m_fail = 1; m_osc = 0; m_bv = 0; end
                    else if (!enable) begin m_st = 0; m_osc = 0; m_bv = 0; end
                    else begin
                        m_cnt++;
                        if (m_took) m_bv = 0;
                        if (m_done && m_canld) begin m_byte = m_nb; m_bv = 1; end
                    end
                end
                default: begin
                    if (clear_fail) begin
                        m_fail = 0;
                        if (enable) begin m_st = 1; m_cnt = 0; m_osc = 1; hist.delete(); end
                        else m_st = 0;
                    end
                end
            endcase
        end
    end

    // Raw stimulus follows the index of the next sample, set well ahead of the sampling edge.
    always @(negedge clk) raw_bit = pattern(pat_mode, hist.size());

    always @(negedge clk) begin
        if (!rst) begin
            check("state", 32'(state), 32'(m_st));
            check("osc_en", 32'(osc_en), 32'(m_osc));
            check("fail", 32'(fail), 32'(m_fail));
            check("byte_valid", 32'(byte_valid), 32'(m_bv));
            if (m_bv) check("byte_out", 32'(byte_out), 32'(m_byte));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int found;
    int nbytes;

    initial begin
        n_tests = 0; n_fail = 0; pat_mode = 0;
        rst = 1'b1; enable = 1'b0; clear_fail = 1'b0; byte_ready = 1'b0; raw_bit = 1'b0;
        #23;
        check("rst_state", 32'(state), 32'd0);
        check("rst_osc_en", 32'(osc_en), 32'd0);
        check("rst_byte_out", 32'(byte_out), 32'd0);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        tick(); rst = 1'b0;
        tick();

        // Alternating samples starting at 0 -> first byte 0x55.
        pat_mode = 0; byte_ready = 1'b1; enable = 1'b1;
        found = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (i == 1) begin
                check("t1_osc_en_latency", 32'(osc_en), 32'd1);
                check("t1_warmup_entry", 32'(state), 32'd1);
            end
            if (byte_valid) begin found = i; break; end
        end
        check("t1_first_byte_cycles", 32'(found), 32'd321);
        check("t1_first_byte", 32'(byte_out), 32'h55);
        enable = 1'b0; tick(); tick();
        check("t1_idle", 32'(state), 32'd0);

        // Stalled consumer: first byte held, two dropped, then a same-cycle reload.
        pat_mode = 3; byte_ready = 1'b0; enable = 1'b1;
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (m_st == 2 && hist.size() == 31 && ((m_cnt + 1) % DIV) == 0) begin found = 1; break; end
        end
        check("t4_reached_byte4", 32'(found), 32'd1);
        check("t4_held_valid", 32'(byte_valid), 32'd1);
        check("t4_held_byte", 32'(byte_out), 32'h92);
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        check("t4_reload_byte", 32'(byte_out), 32'h55);
        check("t4_reload_valid", 32'(byte_valid), 32'd1);
        clear_fail = 1'b1; tick(); clear_fail = 1'b0;
        check("t4_clear_ignored", 32'(state), 32'd2);

        // Asynchronous reset between clock edges while sampling.
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("t5_state", 32'(state), 32'd0);
        check("t5_osc_en", 32'(osc_en), 32'd0);
        check("t5_byte_out", 32'(byte_out), 32'd0);
        check("t5_byte_valid", 32'(byte_valid), 32'd0);
        check("t5_fail", 32'(fail), 32'd0);
        tick(); rst = 1'b0; pat_mode = 0;
        found = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (i == 1) check("t5_rewarm", 32'(state), 32'd1);
            if (state == 2'b10) begin found = i; break; end
        end
        check("t5_warmup_len", 32'(found), 32'd257);
        enable = 1'b0; tick(); tick();

        // Stuck-at-1 source: three 0xFF bytes, then repetition-count failure.
        pat_mode = 1; byte_ready = 1'b1; enable = 1'b1;
        found = -1; nbytes = 0;
        for (int i = 1; i <= 700; i++) begin
            tick();
            if (byte_valid) begin
                nbytes++;
                check("t2_byte_ff", 32'(byte_out), 32'hFF);
            end
            if (fail) begin found = i; break; end
        end
        check("t2_fail_cycles", 32'(found), 32'd513);
        check("t2_byte_count", 32'(nbytes), 32'd3);
        check("t2_state", 32'(state), 32'd3);
        check("t2_osc_off", 32'(osc_en), 32'd0);
        repeat (3) tick();
        check("t2_fail_sticky", 32'(state), 32'd3);

        // Clear with enable high restarts warm-up; clear with enable low goes idle.
        clear_fail = 1'b1; tick(); clear_fail = 1'b0;
        check("t6_warmup", 32'(state), 32'd1);
        check("t6_fail_clr", 32'(fail), 32'd0);
        check("t6_osc_on", 32'(osc_en), 32'd1);
        found = 0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (fail) begin found = 1; break; end
        end
        check("t6_refail", 32'(found), 32'd1);
        enable = 1'b0; clear_fail = 1'b1; tick(); clear_fail = 1'b0;
        check("t6_idle", 32'(state), 32'd0);
        check("t6_idle_fail", 32'(fail), 32'd0);

        // 80% ones with short runs: adaptive-proportion failure at sample 499.
        pat_mode = 2; enable = 1'b1;
        found = -1;
        for (int i = 1; i <= 5000; i++) begin
            tick();
            if (fail) begin found = i; break; end
        end
        check("t3_apt_fail_cycles", 32'(found), 32'd4249);
        check("t3_state", 32'(state), 32'd3);
        enable = 1'b0; clear_fail = 1'b1; tick(); clear_fail = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
